// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported data memory between the instruction-fetch stage
// and the MEM stage of the pipeline. Each accepted request is run through a
// fixed-latency memory access. Read data comes back with a one-cycle done
// pulse. Per-stage stall signals hold the pipeline while its access is
// outstanding.
//
// Parameters
//   LAT         memory access latency in cycles (>= 1)
//   STARVE_MAX  consecutive MEM grants tolerated while IF waits (>= 1)
//
// Ports
//   clk, reset      clock (rising edge) / asynchronous active-low reset
//   if_req/if_addr  fetch request and byte address
//   if_gnt          fetch request accepted this cycle (combinational)
//   if_done         one-cycle pulse, if_rdata valid
//   if_rdata        fetched instruction (holds until the next fetch completes)
//   dm_req/dm_we    data request, 1 = store / 0 = load
//   dm_addr/dm_wdata/dm_xfer_size  data request payload
//   dm_gnt          data request accepted this cycle (combinational)
//   dm_done         one-cycle pulse, load data valid or store complete
//   dm_rdata        load data (holds until the next completing load)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_xfer_size  memory-side command
//   mem_rdata       memory read data
//   stall_if/stall_mem  requester must hold its stage
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_gnt,
  output logic        if_done,
  output logic [31:0] if_rdata,

  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  input  logic [3:0]  dm_xfer_size,
  output logic        dm_gnt,
  output logic        dm_done,
  output logic [63:0] dm_rdata,

  output logic        mem_en,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [3:0]  mem_xfer_size,
  input  logic [63:0] mem_rdata,

  output logic        stall_if,
  output logic        stall_mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);
  localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_MAX);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STV_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic               owner_dm_q, owner_dm_d;
  logic               lat_we_q, lat_we_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [63:0]        mem_addr_q, mem_addr_d;
  logic [63:0]        mem_wdata_q, mem_wdata_d;
  logic [3:0]         mem_size_q, mem_size_d;
  logic [31:0]        if_rdata_q, if_rdata_d;
  logic [63:0]        dm_rdata_q, dm_rdata_d;
  logic               if_done_q, if_done_d;
  logic               dm_done_q, dm_done_d;

  logic               if_wins;
  logic               if_gnt_w;
  logic               dm_gnt_w;

  // MEM wins by default; IF wins when it is alone or has been passed over
  // STARVE_MAX times. Grants are gated by reset so nothing is accepted while
  // the block is held in reset.
  always_comb begin
    if_wins  = if_req & (~dm_req | (starve_cnt_q == STV_LIMIT));
    if_gnt_w = reset & (state_q == IDLE) & if_req & if_wins;
    dm_gnt_w = reset & (state_q == IDLE) & dm_req & ~if_wins;
  end

  // Starvation counter: counts MEM grants that leave a waiting IF behind and
  // resets whenever IF is served or stops asking.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (if_gnt_w || !if_req) begin
      starve_cnt_d = '0;
    end else if (dm_gnt_w && (starve_cnt_q != STV_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Transaction sequencer: IDLE latches the winner's command, BUSY counts the
  // memory latency, and RESP presents the done pulse for one cycle.
  // mem_we is only a strobe for the first BUSY cycle, so the latched store
  // flag is kept separately to decide whether read data is captured.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_dm_d  = owner_dm_q;
    lat_we_d    = lat_we_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = if_done_q;
    dm_done_d   = dm_done_q;

    unique case (state_q)
      IDLE: begin
        if (if_gnt_w) begin
          owner_dm_d  = 1'b0;
          lat_we_d    = 1'b0;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_size_d  = 4'd4;
          cnt_d       = CNT_INIT;
          state_d     = BUSY;
        end else if (dm_gnt_w) begin
          owner_dm_d  = 1'b1;
          lat_we_d    = dm_we;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_size_d  = dm_xfer_size;
          cnt_d       = CNT_INIT;
          state_d     = BUSY;
        end
      end

      BUSY: begin
        mem_we_d = 1'b0;
        if (cnt_q == '0) begin
          mem_en_d = 1'b0;
          if (owner_dm_q) begin
            if (!lat_we_q) begin
              dm_rdata_d = mem_rdata;
            end
            dm_done_d = 1'b1;
          end else begin
            if_rdata_d = mem_rdata[31:0];
            if_done_d  = 1'b1;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RESP: begin
        if_done_d = 1'b0;
        dm_done_d = 1'b0;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state, including the memory command and the returned data, is
  // cleared asynchronously so a reset mid-access aborts with no done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      starve_cnt_q <= '0;
      owner_dm_q   <= 1'b0;
      lat_we_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_size_q   <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_done_q    <= 1'b0;
      dm_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      starve_cnt_q <= starve_cnt_d;
      owner_dm_q   <= owner_dm_d;
      lat_we_q     <= lat_we_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_size_q   <= mem_size_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_done_q    <= if_done_d;
      dm_done_q    <= dm_done_d;
    end
  end

  assign if_gnt        = if_gnt_w;
  assign dm_gnt        = dm_gnt_w;
  assign if_done       = if_done_q;
  assign dm_done       = dm_done_q;
  assign if_rdata      = if_rdata_q;
  assign dm_rdata      = dm_rdata_q;
  assign mem_en        = mem_en_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_xfer_size = mem_size_q;

  // A stage stalls while it is requesting, except in its own done cycle.
  assign stall_if  = if_req & ~if_done_q;
  assign stall_mem = dm_req & ~dm_done_q;

endmodule
